// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encodings, bus owner
// codes and bus access size codes (size codes match the MEM-stage ram_size).
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_e;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog for mem_bus_arbiter (built only with MEM_ARB_TIMEOUT_EN).
// The count is held at zero while the arbiter is idle, so it starts from zero
// on entry to ADDR and advances every cycle spent in ADDR or DATA.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: cleared while idle, incremented while a transaction is open.
  always_comb begin
    cnt_d = '0;
    if (active_i) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires in the cycle whose closing edge would bring the count to the limit.
  assign timeout_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access.
// One transaction at a time: IDLE -> ADDR (bus_req held until addr_ok) ->
// DATA (wait for data_ok) -> IDLE with a one-cycle done pulse to the owner.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
// Bus handshake: bus_req_o rises with all bus_* fields registered and stable;
// the address phase completes in the cycle bus_addr_ok_i is high, after which
// bus_req_o drops; bus_data_ok_i is honoured only in DATA and completes it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic [DATA_WIDTH-1:0] inst_rdata_o,
  output logic                  inst_done_o,
  input  logic                  data_req_i,
  input  logic [3:0]            data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [2:0]            data_size_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_done_o,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  bus_req_o,
  output logic                  bus_wr_o,
  output logic [2:0]            bus_size_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  input  logic                  bus_addr_ok_i,
  input  logic                  bus_data_ok_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  bus_err_o
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_wr_q, bus_wr_d;
  logic [2:0]            bus_size_q, bus_size_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_wstrb_q, bus_wstrb_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  inst_done_q, inst_done_d;
  logic                  data_done_q, data_done_d;
  logic                  discard_q, discard_d;
  logic                  bus_err_q, bus_err_d;

  logic                  inst_elig, data_elig, pick_data;
  logic                  finish;
  logic [DATA_WIDTH-1:0] fin_rdata;
  logic                  timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (state_q != ST_IDLE),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A requester whose done is high this cycle is not re-granted; a flushed
  // fetch is never granted.
  assign inst_elig = inst_req_i & ~inst_done_q & ~flush_i;
  assign data_elig = data_req_i & ~data_done_q;
  assign pick_data = data_elig & ((DATA_PRIORITY != 0) | ~inst_elig);

  // Next-state and datapath: grant, address phase, data phase, completion.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    discard_d    = discard_q;
    bus_err_d    = 1'b0;
    finish       = 1'b0;
    fin_rdata    = bus_rdata_i;

    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (pick_data) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_DATA;
          bus_req_d   = 1'b1;
          bus_wr_d    = |data_we_i;
          bus_size_d  = data_size_i;
          bus_addr_d  = data_addr_i;
          bus_wdata_d = data_wdata_i;
          bus_wstrb_d = data_we_i;
        end else if (inst_elig) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_INST;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_size_d  = SIZE_WORD;
          bus_addr_d  = inst_addr_i;
          bus_wdata_d = '0;
          bus_wstrb_d = 4'b0000;
        end
      end
      ST_ADDR: begin
        if (owner_q == OWN_INST && flush_i) discard_d = 1'b1;
        if (bus_addr_ok_i) begin
          state_d   = ST_DATA;
          bus_req_d = 1'b0;
        end else if (timeout) begin
          finish    = 1'b1;
          fin_rdata = '0;
          bus_err_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (owner_q == OWN_INST && flush_i) discard_d = 1'b1;
        if (bus_data_ok_i) begin
          finish = 1'b1;
        end else if (timeout) begin
          finish    = 1'b1;
          fin_rdata = '0;
          bus_err_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        bus_req_d = 1'b0;
      end
    endcase

    if (finish) begin
      state_d   = ST_IDLE;
      owner_d   = OWN_NONE;
      bus_req_d = 1'b0;
      discard_d = 1'b0;
      if (owner_q == OWN_DATA) begin
        data_done_d  = 1'b1;
        data_rdata_d = fin_rdata;
      end else if (owner_q == OWN_INST && !(discard_q || flush_i)) begin
        inst_done_d  = 1'b1;
        inst_rdata_d = fin_rdata;
      end
    end
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      discard_q    <= discard_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign inst_rdata_o = inst_rdata_q;
  assign inst_done_o  = inst_done_q;
  assign data_rdata_o = data_rdata_q;
  assign data_done_o  = data_done_q;
  assign bus_req_o    = bus_req_q;
  assign bus_wr_o     = bus_wr_q;
  assign bus_size_o   = bus_size_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign bus_wstrb_o  = bus_wstrb_q;
  assign bus_err_o    = bus_err_q;

  assign stall_req_o = (data_req_i & ~data_done_q) |
                       (inst_req_i & ~inst_done_q & ~flush_i);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 1ns after a rising edge,
// outputs are checked 1ns later; "cycle N" is the interval after edge N.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_rdata_o;
  logic        inst_done_o;
  logic        data_req_i = 1'b0;
  logic [3:0]  data_we_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [2:0]  data_size_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_done_o;
  logic        flush_i = 1'b0;
  logic        stall_req_o;
  logic        bus_req_o;
  logic        bus_wr_o;
  logic [2:0]  bus_size_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_addr_ok_i = 1'b0;
  logic        bus_data_ok_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_rdata_o(inst_rdata_o), .inst_done_o(inst_done_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_size_i(data_size_i),
    .data_rdata_o(data_rdata_o), .data_done_o(data_done_o),
    .flush_i(flush_i), .stall_req_o(stall_req_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_size_o(bus_size_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All outputs must be zero after reset (stall is zero with no requests).
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if ({bus_req_o, bus_wr_o, bus_size_o, bus_wstrb_o} !== 9'd0) begin n_fail++; $display("FAIL reset_bus_ctrl: got %h want 0", {bus_req_o, bus_wr_o, bus_size_o, bus_wstrb_o}); end
    n_checks++; if ({bus_addr_o, bus_wdata_o} !== 64'd0) begin n_fail++; $display("FAIL reset_bus_addr_wdata: got %h want 0", {bus_addr_o, bus_wdata_o}); end
    n_checks++; if ({inst_rdata_o, data_rdata_o} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {inst_rdata_o, data_rdata_o}); end
    n_checks++; if ({inst_done_o, data_done_o, bus_err_o, stall_req_o} !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {inst_done_o, data_done_o, bus_err_o, stall_req_o}); end
    #19 rst_n = 1'b1;
    step();
  endtask

  // Minimum-latency fetch: req c0, addr_ok c1, data_ok c2, done c3.
  task automatic test_fetch();
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_0000; #1;
    n_checks++; if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b want 1", stall_req_o); end
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL fetch_req_c0: got %b want 0", bus_req_o); end
    step(); bus_addr_ok_i = 1'b1; #1;
    n_checks++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL fetch_req_c1: got %b want 1", bus_req_o); end
    n_checks++; if ({bus_size_o, bus_wr_o, bus_wstrb_o} !== {3'd2, 1'b0, 4'd0}) begin n_fail++; $display("FAIL fetch_fields: got %h want %h", {bus_size_o, bus_wr_o, bus_wstrb_o}, {3'd2, 1'b0, 4'd0}); end
    n_checks++; if (bus_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_addr: got %h want bfc00000", bus_addr_o); end
    step(); bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h3C1D_0001; #1;
    n_checks++; if ({bus_req_o, inst_done_o, stall_req_o} !== 3'b001) begin n_fail++; $display("FAIL fetch_c2: req/done/stall got %b want 001", {bus_req_o, inst_done_o, stall_req_o}); end
    n_checks++; if ({bus_size_o, bus_wr_o} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL fetch_fields_c2: got %h want 4", {bus_size_o, bus_wr_o}); end
    step(); bus_data_ok_i = 1'b0; #1;
    n_checks++; if (inst_done_o !== 1'b1) begin n_fail++; $display("FAIL fetch_done_c3: got %b want 1", inst_done_o); end
    n_checks++; if (inst_rdata_o !== 32'h3C1D_0001) begin n_fail++; $display("FAIL fetch_rdata: got %h want 3c1d0001", inst_rdata_o); end
    n_checks++; if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c3: got %b want 0", stall_req_o); end
    inst_req_i = 1'b0;
    step();
    n_checks++; if ({inst_done_o, bus_req_o} !== 2'b00) begin n_fail++; $display("FAIL fetch_c4: done/req got %b want 00", {inst_done_o, bus_req_o}); end
  endtask

  // Byte store with a delayed addr_ok, a stray data_ok during ADDR, and a wait in DATA.
  task automatic test_byte_store();
    data_req_i = 1'b1; data_we_i = 4'b0100; data_addr_i = 32'h8000_1002;
    data_wdata_i = 32'h00AB_0000; data_size_i = 3'd0;
    step(); bus_data_ok_i = 1'b1; bus_rdata_i = 32'h0BAD_0BAD; #1;
    n_checks++; if ({bus_req_o, bus_wr_o, bus_wstrb_o, bus_size_o} !== {1'b1, 1'b1, 4'b0100, 3'd0}) begin n_fail++; $display("FAIL store_fields: got %h want %h", {bus_req_o, bus_wr_o, bus_wstrb_o, bus_size_o}, {1'b1, 1'b1, 4'b0100, 3'd0}); end
    n_checks++; if ({bus_addr_o, bus_wdata_o} !== {32'h8000_1002, 32'h00AB_0000}) begin n_fail++; $display("FAIL store_addr_wdata: got %h want 8000100200ab0000", {bus_addr_o, bus_wdata_o}); end
    step(); bus_data_ok_i = 1'b0; bus_addr_ok_i = 1'b1; #1;
    n_checks++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL store_req_held: got %b want 1", bus_req_o); end
    step(); bus_addr_ok_i = 1'b0; #1;
    n_checks++; if ({bus_req_o, data_done_o} !== 2'b00) begin n_fail++; $display("FAIL store_c3: req/done got %b want 00", {bus_req_o, data_done_o}); end
    step(); bus_data_ok_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF; #1;
    n_checks++; if (data_done_o !== 1'b0) begin n_fail++; $display("FAIL store_done_early: got %b want 0", data_done_o); end
    step(); bus_data_ok_i = 1'b0; #1;
    n_checks++; if (data_done_o !== 1'b1) begin n_fail++; $display("FAIL store_done: got %b want 1", data_done_o); end
    n_checks++; if (data_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_rdata: got %h want deadbeef", data_rdata_o); end
    n_checks++; if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b want 0", stall_req_o); end
    data_req_i = 1'b0; data_we_i = 4'b0000;
    step();
    n_checks++; if ({data_done_o, bus_req_o} !== 2'b00) begin n_fail++; $display("FAIL store_after: done/req got %b want 00", {data_done_o, bus_req_o}); end
  endtask

  // Both requests in one cycle: data first, inst granted while data_done is high.
  task automatic test_back_to_back();
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_0004;
    data_req_i = 1'b1; data_we_i = 4'b0000; data_addr_i = 32'h8000_0010; data_size_i = 3'd2;
    step(); bus_addr_ok_i = 1'b1; #1;
    n_checks++; if ({bus_req_o, bus_wr_o, bus_addr_o} !== {1'b1, 1'b0, 32'h8000_0010}) begin n_fail++; $display("FAIL b2b_data_first: got %h want 280000010", {bus_req_o, bus_wr_o, bus_addr_o}); end
    step(); bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h1111_2222; #1;
    step(); bus_data_ok_i = 1'b0; data_req_i = 1'b0; #1;
    n_checks++; if ({data_done_o, inst_done_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_data_done: data/inst got %b want 10", {data_done_o, inst_done_o}); end
    n_checks++; if (data_rdata_o !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_data_rdata: got %h want 11112222", data_rdata_o); end
    n_checks++; if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_inst_pending: got %b want 1", stall_req_o); end
    step(); bus_addr_ok_i = 1'b1; #1;
    n_checks++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'hBFC0_0004}) begin n_fail++; $display("FAIL b2b_inst_grant: got %h want 1bfc00004", {bus_req_o, bus_addr_o}); end
    n_checks++; if ({bus_size_o, bus_wr_o, bus_wstrb_o} !== {3'd2, 1'b0, 4'd0}) begin n_fail++; $display("FAIL b2b_inst_fields: got %h want %h", {bus_size_o, bus_wr_o, bus_wstrb_o}, {3'd2, 1'b0, 4'd0}); end
    step(); bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h3333_4444; #1;
    step(); bus_data_ok_i = 1'b0; #1;
    n_checks++; if ({inst_done_o, data_done_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_inst_done: inst/data got %b want 10", {inst_done_o, data_done_o}); end
    n_checks++; if (inst_rdata_o !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_inst_rdata: got %h want 33334444", inst_rdata_o); end
    n_checks++; if (data_rdata_o !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_data_rdata_hold: got %h want 11112222", data_rdata_o); end
    inst_req_i = 1'b0;
    step();
  endtask

  // Flush while a fetch is in DATA: bus completes, done and rdata suppressed.
  task automatic test_flush();
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_0008;
    step(); bus_addr_ok_i = 1'b1;
    step(); bus_addr_ok_i = 1'b0; flush_i = 1'b1; #1;
    n_checks++; if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_req_o); end
    step(); flush_i = 1'b0; inst_req_i = 1'b0; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h5555_6666;
    step(); bus_data_ok_i = 1'b0; #1;
    n_checks++; if (inst_done_o !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", inst_done_o); end
    n_checks++; if (inst_rdata_o !== 32'h3333_4444) begin n_fail++; $display("FAIL flush_rdata_kept: got %h want 33334444", inst_rdata_o); end
    step();
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_regrant: got %b want 0", bus_req_o); end
    // A following fetch completes normally, so the discard flag has cleared.
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_000C;
    step(); bus_addr_ok_i = 1'b1;
    step(); bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h7777_8888;
    step(); bus_data_ok_i = 1'b0; #1;
    n_checks++; if ({inst_done_o, inst_rdata_o} !== {1'b1, 32'h7777_8888}) begin n_fail++; $display("FAIL flush_next_fetch: got %h want 177778888", {inst_done_o, inst_rdata_o}); end
    inst_req_i = 1'b0;
    step();
  endtask

  // Watchdog: addr_ok never arrives; err and done pulse after 8 ADDR cycles.
  task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
    data_req_i = 1'b1; data_we_i = 4'b0000; data_addr_i = 32'h8000_0030; data_size_i = 3'd2;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++; if ({bus_req_o, bus_err_o, data_done_o} !== 3'b100) begin n_fail++; $display("FAIL timeout_wait c%0d: req/err/done got %b want 100", c, {bus_req_o, bus_err_o, data_done_o}); end
    end
    step(); #1;
    n_checks++; if ({bus_req_o, bus_err_o, data_done_o} !== 3'b011) begin n_fail++; $display("FAIL timeout_fire: req/err/done got %b want 011", {bus_req_o, bus_err_o, data_done_o}); end
    n_checks++; if (data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", data_rdata_o); end
    data_req_i = 1'b0;
    step();
    n_checks++; if ({bus_req_o, bus_err_o, data_done_o} !== 3'b000) begin n_fail++; $display("FAIL timeout_idle: req/err/done got %b want 000", {bus_req_o, bus_err_o, data_done_o}); end
`endif
  endtask

  // Asynchronous reset during ADDR drops bus_req_o before any clock edge.
  task automatic test_reset_mid();
    data_req_i = 1'b1; data_we_i = 4'b1111; data_addr_i = 32'h8000_0020;
    data_wdata_i = 32'h1234_5678; data_size_i = 3'd2;
    step(); #1;
    n_checks++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b want 1", bus_req_o); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_async: got %b want 0", bus_req_o); end
    data_req_i = 1'b0; data_we_i = 4'b0000; data_wdata_i = '0;
    #2 rst_n = 1'b1;
    step(); #1;
    n_checks++; if ({bus_req_o, bus_wr_o, bus_size_o, bus_wstrb_o} !== 9'd0) begin n_fail++; $display("FAIL rstmid_bus_ctrl: got %h want 0", {bus_req_o, bus_wr_o, bus_size_o, bus_wstrb_o}); end
    n_checks++; if ({bus_addr_o, bus_wdata_o} !== 64'd0) begin n_fail++; $display("FAIL rstmid_bus_addr_wdata: got %h want 0", {bus_addr_o, bus_wdata_o}); end
    n_checks++; if ({inst_rdata_o, data_rdata_o} !== 64'd0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", {inst_rdata_o, data_rdata_o}); end
    n_checks++; if ({inst_done_o, data_done_o, bus_err_o, stall_req_o} !== 4'd0) begin n_fail++; $display("FAIL rstmid_flags: got %b want 0000", {inst_done_o, data_done_o, bus_err_o, stall_req_o}); end
    step();
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stays_idle: got %b want 0", bus_req_o); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_store();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
